// File: rtl/fpu_add_sub_pipe.sv
// Sign-magnitude mantissa add/subtract stage between FPU pre- and post-normalisation.
// Elastic valid/ready pipeline; stages after the adder are plain register slices.
module fpu_add_sub_pipe #(
   parameter int unsigned  PRECISION   = 32,
   parameter int unsigned  PIPE_STAGES = 2,
   parameter int unsigned  TAG_WIDTH   = 4,
   localparam int unsigned EXP_W       = (PRECISION == 64) ? 11 : 8,
   localparam int unsigned MANT_W      = (PRECISION == 64) ? 52 : 23
) (
   input  logic                 I_Clk,
   input  logic                 I_Reset,
   input  logic                 I_PreNorm_Valid,
   output logic                 O_PreNorm_Ready,
   input  logic                 I_Op_Sub,
   input  logic [EXP_W-1:0]     I_PreNorm_Exp,
   input  logic                 I_Sign_Op1,
   input  logic [MANT_W:0]      I_Mant_Op1,
   input  logic                 I_Sign_Op2,
   input  logic [MANT_W:0]      I_Mant_Op2,
   input  logic [TAG_WIDTH-1:0] I_Tag,
   output logic                 O_Add_Valid,
   input  logic                 I_Add_Ready,
   output logic                 O_Add_Sign,
   output logic [EXP_W-1:0]     O_Add_Exp,
   output logic [MANT_W+1:0]    O_Add_Mant,
   output logic                 O_Add_Zero,
   output logic [TAG_WIDTH-1:0] O_Add_Tag,
   output logic                 O_Busy
);

   localparam int unsigned NSTG  = (PIPE_STAGES < 2) ? 2 : ((PIPE_STAGES > 4) ? 4 : PIPE_STAGES);
   localparam int unsigned IN_W  = MANT_W + 1;
   localparam int unsigned SUM_W = MANT_W + 2;
   // result record: {sign, exp, mant, zero, tag}
   localparam int unsigned RES_W = 1 + EXP_W + SUM_W + 1 + TAG_WIDTH;

   logic                 adv1_c, adv2_c, adv3_c, adv4_c;

   logic                 v1_q, v1_d;
   logic [IN_W-1:0]      big_q, big_d;
   logic [IN_W-1:0]      small_q, small_d;
   logic                 sign1_q, sign1_d;
   logic                 sub1_q, sub1_d;
   logic [EXP_W-1:0]     exp1_q, exp1_d;
   logic [TAG_WIDTH-1:0] tag1_q, tag1_d;

   logic                 v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
   logic [RES_W-1:0]     r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;

   logic                 eff_sign2_c;
   logic                 op2_gt_c;
   logic [SUM_W-1:0]     sum_c;
   logic                 sum_zero_c;
   logic                 sum_sign_c;
   logic                 last_v_c;
   logic [RES_W-1:0]     last_r_c;

   // A stage advances when it is empty or its successor advances.
   always_comb begin
      adv4_c = 1'b0;
      adv3_c = 1'b0;
      if (NSTG == 4) begin
         adv4_c = ~v4_q | I_Add_Ready;
         adv3_c = ~v3_q | adv4_c;
      end else if (NSTG == 3) begin
         adv3_c = ~v3_q | I_Add_Ready;
      end
      adv2_c = (NSTG >= 3) ? (~v2_q | adv3_c) : (~v2_q | I_Add_Ready);
      adv1_c = ~v1_q | adv2_c;
   end

   assign O_PreNorm_Ready = adv1_c;

   // Stage 1: fold the mode into op2's sign and order operands by magnitude.
   always_comb begin
      eff_sign2_c = I_Sign_Op2 ^ I_Op_Sub;
      op2_gt_c    = I_Mant_Op2 > I_Mant_Op1;
      v1_d        = adv1_c ? I_PreNorm_Valid : v1_q;
      big_d       = big_q;
      small_d     = small_q;
      sign1_d     = sign1_q;
      sub1_d      = sub1_q;
      exp1_d      = exp1_q;
      tag1_d      = tag1_q;
      if (adv1_c && I_PreNorm_Valid) begin
         big_d   = op2_gt_c ? I_Mant_Op2 : I_Mant_Op1;
         small_d = op2_gt_c ? I_Mant_Op1 : I_Mant_Op2;
         sign1_d = op2_gt_c ? eff_sign2_c : I_Sign_Op1;
         sub1_d  = I_Sign_Op1 ^ eff_sign2_c;
         exp1_d  = I_PreNorm_Exp;
         tag1_d  = I_Tag;
      end
   end

   // Stage 2: big >= small, so the difference never borrows and the sum fits in SUM_W.
   always_comb begin
      sum_c      = sub1_q ? (SUM_W'(big_q) - SUM_W'(small_q))
                          : (SUM_W'(big_q) + SUM_W'(small_q));
      sum_zero_c = (sum_c == '0);
      // exact cancellation yields +0; a same-sign zero keeps its sign
      sum_sign_c = (sub1_q && sum_zero_c) ? 1'b0 : sign1_q;
      v2_d       = adv2_c ? v1_q : v2_q;
      r2_d       = r2_q;
      if (adv2_c && v1_q) begin
         r2_d = {sum_sign_c, exp1_q, sum_c, sum_zero_c, tag1_q};
      end
   end

   // Optional register slices; unused ones stay empty and hold zero.
   always_comb begin
      v3_d = 1'b0;
      r3_d = r3_q;
      v4_d = 1'b0;
      r4_d = r4_q;
      if (NSTG >= 3) begin
         v3_d = adv3_c ? v2_q : v3_q;
         if (adv3_c && v2_q) begin
            r3_d = r2_q;
         end
      end
      if (NSTG == 4) begin
         v4_d = adv4_c ? v3_q : v4_q;
         if (adv4_c && v3_q) begin
            r4_d = r3_q;
         end
      end
   end

   always_ff @(posedge I_Clk) begin
      if (I_Reset) begin
         v1_q    <= 1'b0;
         big_q   <= '0;
         small_q <= '0;
         sign1_q <= 1'b0;
         sub1_q  <= 1'b0;
         exp1_q  <= '0;
         tag1_q  <= '0;
         v2_q    <= 1'b0;
         r2_q    <= '0;
         v3_q    <= 1'b0;
         r3_q    <= '0;
         v4_q    <= 1'b0;
         r4_q    <= '0;
      end else begin
         v1_q    <= v1_d;
         big_q   <= big_d;
         small_q <= small_d;
         sign1_q <= sign1_d;
         sub1_q  <= sub1_d;
         exp1_q  <= exp1_d;
         tag1_q  <= tag1_d;
         v2_q    <= v2_d;
         r2_q    <= r2_d;
         v3_q    <= v3_d;
         r3_q    <= r3_d;
         v4_q    <= v4_d;
         r4_q    <= r4_d;
      end
   end

   // Output taps the last populated slice (selection is fixed at elaboration).
   always_comb begin
      last_v_c = v2_q;
      last_r_c = r2_q;
      if (NSTG == 3) begin
         last_v_c = v3_q;
         last_r_c = r3_q;
      end else if (NSTG == 4) begin
         last_v_c = v4_q;
         last_r_c = r4_q;
      end
   end

   assign O_Add_Valid = last_v_c;
   assign {O_Add_Sign, O_Add_Exp, O_Add_Mant, O_Add_Zero, O_Add_Tag} = last_r_c;
   assign O_Busy = v1_q | v2_q | v3_q | v4_q;

endmodule

// File: tb/tb_fpu_add_sub_pipe.sv
// Bench for fpu_add_sub_pipe: instances with 2, 3 and 4 stages share the operand bus,
// each with its own handshake and scoreboard queue.
module tb_fpu_add_sub_pipe;

   typedef struct packed {
      logic        sign;
      logic [7:0]  e;
      logic [24:0] mant;
      logic        zero;
      logic [3:0]  tag;
   } res_t;

   typedef struct {
      logic        sub;
      logic [7:0]  e;
      logic        s1;
      logic [23:0] m1;
      logic        s2;
      logic [23:0] m2;
      logic [3:0]  tag;
      res_t        res;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        op_sub, sgn1, sgn2;
   logic [7:0]  exp_in;
   logic [23:0] m1, m2;
   logic [3:0]  tag_in;

   logic        in_vld  [3];
   logic        in_rdy  [3];
   logic        out_vld [3];
   logic        out_rdy [3];
   logic        busy    [3];
   logic        out_sign[3];
   logic        out_zero[3];
   logic [7:0]  out_exp [3];
   logic [24:0] out_mant[3];
   logic [3:0]  out_tag [3];

   res_t        cur_exp;
   res_t        sbq[3][$];
   res_t        hold_r[3];
   logic        hold_v[3];
   int          n_vec, n_err, cyc;
   logic        rand_en;
   vec_t        vt[12];

   fpu_add_sub_pipe #(.PRECISION(32), .PIPE_STAGES(2), .TAG_WIDTH(4)) u_p2 (
      .I_Clk(clk), .I_Reset(rst), .I_PreNorm_Valid(in_vld[0]), .O_PreNorm_Ready(in_rdy[0]),
      .I_Op_Sub(op_sub), .I_PreNorm_Exp(exp_in), .I_Sign_Op1(sgn1), .I_Mant_Op1(m1),
      .I_Sign_Op2(sgn2), .I_Mant_Op2(m2), .I_Tag(tag_in), .O_Add_Valid(out_vld[0]),
      .I_Add_Ready(out_rdy[0]), .O_Add_Sign(out_sign[0]), .O_Add_Exp(out_exp[0]),
      .O_Add_Mant(out_mant[0]), .O_Add_Zero(out_zero[0]), .O_Add_Tag(out_tag[0]), .O_Busy(busy[0]));

   fpu_add_sub_pipe #(.PRECISION(32), .PIPE_STAGES(3), .TAG_WIDTH(4)) u_p3 (
      .I_Clk(clk), .I_Reset(rst), .I_PreNorm_Valid(in_vld[1]), .O_PreNorm_Ready(in_rdy[1]),
      .I_Op_Sub(op_sub), .I_PreNorm_Exp(exp_in), .I_Sign_Op1(sgn1), .I_Mant_Op1(m1),
      .I_Sign_Op2(sgn2), .I_Mant_Op2(m2), .I_Tag(tag_in), .O_Add_Valid(out_vld[1]),
      .I_Add_Ready(out_rdy[1]), .O_Add_Sign(out_sign[1]), .O_Add_Exp(out_exp[1]),
      .O_Add_Mant(out_mant[1]), .O_Add_Zero(out_zero[1]), .O_Add_Tag(out_tag[1]), .O_Busy(busy[1]));

   fpu_add_sub_pipe #(.PRECISION(32), .PIPE_STAGES(4), .TAG_WIDTH(4)) u_p4 (
      .I_Clk(clk), .I_Reset(rst), .I_PreNorm_Valid(in_vld[2]), .O_PreNorm_Ready(in_rdy[2]),
      .I_Op_Sub(op_sub), .I_PreNorm_Exp(exp_in), .I_Sign_Op1(sgn1), .I_Mant_Op1(m1),
      .I_Sign_Op2(sgn2), .I_Mant_Op2(m2), .I_Tag(tag_in), .O_Add_Valid(out_vld[2]),
      .I_Add_Ready(out_rdy[2]), .O_Add_Sign(out_sign[2]), .O_Add_Exp(out_exp[2]),
      .O_Add_Mant(out_mant[2]), .O_Add_Zero(out_zero[2]), .O_Add_Tag(out_tag[2]), .O_Busy(busy[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: signed integer sum of the two effective operands.
   function automatic res_t model(input logic sub, input logic [7:0] e, input logic s1,
                                  input logic [23:0] a, input logic s2, input logic [23:0] b,
                                  input logic [3:0] t);
      res_t   r;
      logic   es2;
      longint va, vb, sum;
      es2    = s2 ^ sub;
      va     = s1  ? -longint'(a) : longint'(a);
      vb     = es2 ? -longint'(b) : longint'(b);
      sum    = va + vb;
      r.e    = e;
      r.tag  = t;
      r.zero = (sum == 0);
      r.mant = 25'((sum < 0) ? -sum : sum);
      r.sign = (sum < 0) ? 1'b1 : ((sum > 0) ? 1'b0 : (s1 & es2));
      return r;
   endfunction

   function automatic vec_t mk(input logic sub, input logic [7:0] e, input logic s1,
                               input logic [23:0] a, input logic s2, input logic [23:0] b,
                               input logic [3:0] t, input logic rs, input logic [24:0] rm,
                               input logic rz);
      vec_t v;
      v.sub = sub; v.e = e; v.s1 = s1; v.m1 = a; v.s2 = s2; v.m2 = b; v.tag = t;
      v.res = {rs, e, rm, rz, t};
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   task automatic drive_vec(input vec_t v);
      op_sub = v.sub; exp_in = v.e; sgn1 = v.s1; m1 = v.m1; sgn2 = v.s2; m2 = v.m2;
      tag_in = v.tag;
      cur_exp = v.res;
   endtask

   task automatic rand_op(input logic [3:0] t);
      op_sub = 1'($urandom_range(0, 1));
      sgn1   = 1'($urandom_range(0, 1));
      sgn2   = 1'($urandom_range(0, 1));
      exp_in = 8'($urandom);
      m1     = ($urandom_range(0, 15) == 0) ? 24'h0 : 24'($urandom);
      m2     = ($urandom_range(0, 3) == 0) ? m1 : 24'($urandom);
      tag_in = t;
      cur_exp = model(op_sub, exp_in, sgn1, m1, sgn2, m2, t);
   endtask

   // Present the current operand to the instances in mask until each has taken it.
   task automatic send(input logic [2:0] mask);
      logic [2:0] pend;
      pend = mask;
      for (int i = 0; i < 3; i++) in_vld[i] = mask[i];
      for (int t = 0; t < 500 && pend != 3'b000; t++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) if (in_vld[i] && in_rdy[i]) pend[i] = 1'b0;
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) if (!pend[i]) in_vld[i] = 1'b0;
      end
      if (pend != 3'b000) begin
         check("send_timeout", 64'(pend), 64'd0);
         for (int i = 0; i < 3; i++) in_vld[i] = 1'b0;
      end
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         @(posedge clk); #1;
         done = (sbq[0].size() == 0) && (sbq[1].size() == 0) && (sbq[2].size() == 0) &&
                !busy[0] && !busy[1] && !busy[2];
      end
      check("drain_complete", 64'(done), 64'd1);
   endtask

   initial begin
      logic [2:0] rdy_all;
      int         t0;
      res_t       act, expd;
      n_vec = 0; n_err = 0; cyc = 0; rand_en = 1'b0; rst = 1'b1;
      op_sub = 1'b0; sgn1 = 1'b0; sgn2 = 1'b0; exp_in = '0; m1 = '0; m2 = '0; tag_in = '0;
      cur_exp = '0;
      for (int i = 0; i < 3; i++) begin
         in_vld[i] = 1'b0; out_rdy[i] = 1'b1; hold_v[i] = 1'b0; hold_r[i] = '0;
      end

      vt[0]  = mk(1'b0, 8'h7F, 1'b0, 24'h800000, 1'b0, 24'h800000, 4'd3,  1'b0, 25'h1000000, 1'b0);
      vt[1]  = mk(1'b1, 8'h80, 1'b0, 24'h800000, 1'b0, 24'hC00000, 4'd4,  1'b1, 25'h0400000, 1'b0);
      vt[2]  = mk(1'b1, 8'h81, 1'b0, 24'h800000, 1'b0, 24'h800000, 4'd5,  1'b0, 25'h0000000, 1'b1);
      vt[3]  = mk(1'b0, 8'h00, 1'b1, 24'h000000, 1'b1, 24'h000000, 4'd6,  1'b1, 25'h0000000, 1'b1);
      vt[4]  = mk(1'b0, 8'hFF, 1'b0, 24'h000000, 1'b0, 24'h000000, 4'd7,  1'b0, 25'h0000000, 1'b1);
      vt[5]  = mk(1'b0, 8'h10, 1'b0, 24'h800000, 1'b1, 24'hFFFFFF, 4'd8,  1'b1, 25'h07FFFFF, 1'b0);
      vt[6]  = mk(1'b1, 8'h20, 1'b1, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 4'd9,  1'b0, 25'h0000000, 1'b1);
      vt[7]  = mk(1'b0, 8'h30, 1'b1, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 4'hA,  1'b1, 25'h1FFFFFE, 1'b0);
      vt[8]  = mk(1'b1, 8'h40, 1'b0, 24'h000001, 1'b1, 24'h000002, 4'hB,  1'b0, 25'h0000003, 1'b0);
      vt[9]  = mk(1'b0, 8'h50, 1'b0, 24'h000005, 1'b1, 24'h000005, 4'hC,  1'b0, 25'h0000000, 1'b1);
      vt[10] = mk(1'b1, 8'h60, 1'b1, 24'h000000, 1'b0, 24'h000000, 4'hD,  1'b1, 25'h0000000, 1'b1);
      vt[11] = mk(1'b0, 8'h70, 1'b0, 24'h000003, 1'b1, 24'h000007, 4'hE,  1'b1, 25'h0000004, 1'b0);

      fork
         forever begin
            @(posedge clk);
            cyc++;
         end
         forever begin
            @(posedge clk); #1;
            if (rand_en) for (int i = 0; i < 3; i++) out_rdy[i] = 1'($urandom_range(0, 1));
         end
         // Monitor: pop/compare on output transfer, push on input transfer, check stalls hold.
         forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               act = {out_sign[i], out_exp[i], out_mant[i], out_zero[i], out_tag[i]};
               if (rst) begin
                  sbq[i].delete();
                  hold_v[i] = 1'b0;
               end else begin
                  if (hold_v[i]) begin
                     check($sformatf("stall_valid_p%0d", i + 2), 64'(out_vld[i]), 64'd1);
                     check($sformatf("stall_hold_p%0d", i + 2), 64'(act), 64'(hold_r[i]));
                  end
                  hold_v[i] = out_vld[i] & ~out_rdy[i];
                  hold_r[i] = act;
                  if (out_vld[i] && out_rdy[i]) begin
                     if (sbq[i].size() == 0) begin
                        check($sformatf("spurious_result_p%0d", i + 2), 64'(act), 64'h0);
                        if (act == '0) check("spurious_result_present", 64'd1, 64'd0);
                     end else begin
                        expd = sbq[i].pop_front();
                        check($sformatf("result_p%0d_tag%0h", i + 2, expd.tag), 64'(act), 64'(expd));
                     end
                  end
                  if (in_vld[i] && in_rdy[i]) sbq[i].push_back(cur_exp);
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         act = {out_sign[i], out_exp[i], out_mant[i], out_zero[i], out_tag[i]};
         check($sformatf("reset_valid_p%0d", i + 2), 64'(out_vld[i]), 64'd0);
         check($sformatf("reset_busy_p%0d", i + 2), 64'(busy[i]), 64'd0);
         check($sformatf("reset_ready_p%0d", i + 2), 64'(in_rdy[i]), 64'd1);
         check($sformatf("reset_data_p%0d", i + 2), 64'(act), 64'd0);
      end
      @(posedge clk); #1;

      // Two-cycle latency on the 2-stage instance.
      drive_vec(vt[0]);
      in_vld[0] = 1'b1;
      @(negedge clk);
      check("latency_c0_valid", 64'(out_vld[0]), 64'd0);
      @(posedge clk); #1;
      in_vld[0] = 1'b0;
      @(negedge clk);
      check("latency_c1_valid", 64'(out_vld[0]), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("latency_c2_valid", 64'(out_vld[0]), 64'd1);
      @(posedge clk); #1;
      drain();

      for (int k = 0; k < 12; k++) begin
         drive_vec(vt[k]);
         send(3'b111);
      end
      drain();

      // Backpressure: two accepts fill the 2-stage pipe, the third waits.
      out_rdy[0] = 1'b0;
      rand_op(4'd1); send(3'b001);
      rand_op(4'd2); send(3'b001);
      rand_op(4'd3);
      in_vld[0] = 1'b1;
      @(negedge clk);
      check("full_ready", 64'(in_rdy[0]), 64'd0);
      check("full_head_tag", 64'(out_tag[0]), 64'd1);
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("stalled_ready", 64'(in_rdy[0]), 64'd0);
         check("stalled_busy", 64'(busy[0]), 64'd1);
      end
      @(posedge clk); #1;
      out_rdy[0] = 1'b1;
      send(3'b001);
      drain();

      // Reset with two ops in flight.
      out_rdy[0] = 1'b0;
      rand_op(4'd5); send(3'b001);
      rand_op(4'd6); send(3'b001);
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_valid", 64'(out_vld[0]), 64'd0);
      check("post_reset_busy", 64'(busy[0]), 64'd0);
      check("post_reset_ready", 64'(in_rdy[0]), 64'd1);
      @(posedge clk); #1;
      out_rdy[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rand_op(4'd9); send(3'b111);
      drain();

      // Full throughput with downstream always ready.
      t0 = cyc;
      for (int k = 0; k < 20; k++) begin
         rand_op(4'(k));
         send(3'b111);
      end
      check("throughput_cycles", 64'(cyc - t0), 64'd20);
      drain();

      // Random stream with random downstream backpressure on every instance.
      rand_en = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         rand_op(4'($urandom));
         send(3'b111);
      end
      rand_en = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) out_rdy[i] = 1'b1;
      drain();

      rdy_all = {in_rdy[2], in_rdy[1], in_rdy[0]};
      check("final_ready", 64'(rdy_all), 64'h7);
      check("final_queues", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
